// File: rtl/tetris_controls.sv
// Button conditioner for tetris: sync, debounce, edge detect, auto-repeat
// and arbitration of six push-buttons into one-cycle command pulses.
module tetris_controls #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 8000000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn_raw,
    output logic       move_left,
    output logic       move_right,
    output logic       move_down,
    output logic       drop,
    output logic       rotate_left,
    output logic       rotate_right,
    output logic [5:0] held
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int RELOAD_I = (REPEAT_RATE > REPEAT_DELAY) ?
                              0 : REPEAT_DELAY - REPEAT_RATE;

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RP_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_RELOAD = RW'(RELOAD_I);

    logic [5:0]    sync1_q;
    logic [5:0]    sync2_q;
    logic [5:0]    held_q;
    logic [5:0]    held_d;
    logic [5:0]    held_prev_q;
    logic [DW-1:0] db_cnt_q [6];
    logic [DW-1:0] db_cnt_d [6];
    logic [RW-1:0] rep_cnt_q [3];
    logic [RW-1:0] rep_cnt_d [3];
    logic [2:0]    rep_req;
    logic [5:0]    rise;
    logic [5:0]    req;
    logic          lr_block;
    logic [5:0]    pulse_q;
    logic [5:0]    pulse_d;

    assign rise = held_q & ~held_prev_q;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            held_d[i]   = held_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != held_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    held_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Repeat counter stays within [0, REPEAT_DELAY-1], so it cannot wrap.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rep_req[i]   = 1'b0;
            rep_cnt_d[i] = rep_cnt_q[i];
            if (!held_q[i] || rise[i]) begin
                rep_cnt_d[i] = '0;
            end else if (rep_cnt_q[i] >= RP_LAST) begin
                rep_req[i]   = 1'b1;
                rep_cnt_d[i] = RP_RELOAD;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        req      = rise | {3'b000, rep_req};
        lr_block = held_q[0] & held_q[1];
        pulse_d[0] = req[0] & ~lr_block;
        pulse_d[1] = req[1] & ~lr_block;
        pulse_d[2] = req[2] & ~req[3];
        pulse_d[3] = req[3];
        pulse_d[4] = req[4] & ~req[5];
        pulse_d[5] = req[5];
        pulse_d    = pulse_d & ~pulse_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            held_q      <= '0;
            held_prev_q <= '0;
            pulse_q     <= '0;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            held_q      <= held_d;
            held_prev_q <= held_q;
            pulse_q     <= pulse_d;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int i = 0; i < 3; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    assign move_left    = pulse_q[0];
    assign move_right   = pulse_q[1];
    assign move_down    = pulse_q[2];
    assign drop         = pulse_q[3];
    assign rotate_left  = pulse_q[4];
    assign rotate_right = pulse_q[5];
    assign held         = held_q;

endmodule
